// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for an 8-bit synchronous FIFO: waits for a full burst,
// drains it under buffer credit and presents the bytes on a valid/ready stream.
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int COUNT_W   = 8,
    parameter int BURST_LEN = 16,
    parameter int BUF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [DATA_W-1:0]  fifo_dout,
    input  logic               fifo_valid,
    input  logic               fifo_empty,
    input  logic               fifo_underflow,
    input  logic [COUNT_W-1:0] fifo_data_count,
    output logic               fifo_rd_en,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic [15:0]        burst_cnt,
    output logic               err
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [COUNT_W-1:0] BURST_LEN_C = COUNT_W'(BURST_LEN);
    localparam logic [COUNT_W-1:0] LAST_BEAT_C = COUNT_W'(BURST_LEN - 1);
    localparam logic [COUNT_W-1:0] BEAT_ONE_C  = COUNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE_C   = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL_C  = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W:0]     CREDIT_C    = (CNT_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    logic [COUNT_W-1:0]  remaining_r;
    logic [COUNT_W-1:0]  out_beat_r;
    logic                inflight_r;
    logic [DATA_W-1:0]   buf_mem_r [BUF_DEPTH];
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CNT_W-1:0]    buf_count_r;
    logic [15:0]         burst_cnt_r;
    logic                err_r;

    logic                rd_en_s;
    logic                push_s;
    logic                write_s;
    logic                pop_s;
    logic                drop_s;
    logic                m_valid_s;
    logic                m_last_s;
    logic [CNT_W:0]      occupancy_s;

    // Read credit, buffer handshakes and stream view of the buffer head.
    always_comb begin
        occupancy_s = {1'b0, buf_count_r} + {{CNT_W{1'b0}}, inflight_r};
        rd_en_s     = (state_r == ST_READ) && !srst && !fifo_empty &&
                      (remaining_r != {COUNT_W{1'b0}}) && (occupancy_s < CREDIT_C);
        m_valid_s   = (buf_count_r != {CNT_W{1'b0}});
        m_last_s    = m_valid_s && (out_beat_r == LAST_BEAT_C);
        push_s      = fifo_valid && (state_r != ST_IDLE) && !srst;
        pop_s       = m_valid_s && m_ready;
        drop_s      = push_s && (buf_count_r == CNT_FULL_C) && !pop_s;
        write_s     = push_s && !drop_s;
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = m_valid_s;
    assign m_last     = m_last_s;
    assign m_data     = m_valid_s ? buf_mem_r[head_r] : {DATA_W{1'b0}};
    assign busy       = (state_r != ST_IDLE);
    assign burst_cnt  = burst_cnt_r;
    assign err        = err_r;

    // Buffer storage; contents are only visible through m_data while valid.
    always_ff @(posedge clk) begin
        if (write_s) begin
            buf_mem_r[tail_r] <= fifo_dout;
        end
    end

    // Burst FSM, buffer bookkeeping, beat counter and sticky error.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r     <= ST_IDLE;
            remaining_r <= {COUNT_W{1'b0}};
            out_beat_r  <= {COUNT_W{1'b0}};
            inflight_r  <= 1'b0;
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            buf_count_r <= {CNT_W{1'b0}};
            burst_cnt_r <= 16'd0;
            err_r       <= 1'b0;
        end else begin
            inflight_r <= rd_en_s;
            if (fifo_underflow || drop_s) begin
                err_r <= 1'b1;
            end
            if (write_s) begin
                tail_r <= tail_r + PTR_ONE_C;
            end
            if (pop_s) begin
                head_r     <= head_r + PTR_ONE_C;
                out_beat_r <= m_last_s ? {COUNT_W{1'b0}} : out_beat_r + BEAT_ONE_C;
            end
            case ({write_s, pop_s})
                2'b10:   buf_count_r <= buf_count_r + CNT_ONE_C;
                2'b01:   buf_count_r <= buf_count_r - CNT_ONE_C;
                default: buf_count_r <= buf_count_r;
            endcase
            case (state_r)
                ST_IDLE: begin
                    if (fifo_data_count >= BURST_LEN_C) begin
                        remaining_r <= BURST_LEN_C;
                        state_r     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_en_s) begin
                        remaining_r <= remaining_r - BEAT_ONE_C;
                        if (remaining_r == BEAT_ONE_C) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave only once every issued read has been delivered downstream.
                    if ((buf_count_r == {CNT_W{1'b0}}) && !inflight_r && !m_valid_s) begin
                        state_r     <= ST_IDLE;
                        burst_cnt_r <= burst_cnt_r + 16'd1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, scripted scenarios and an
// in-order byte scoreboard with burst-position model for m_last.
module tb_fifo_burst_reader;

    localparam int BL = 16;

    logic        clk;
    logic        srst;
    logic [7:0]  fifo_dout;
    logic        fifo_valid;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic [7:0]  fifo_data_count;
    logic        fifo_rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic [15:0] burst_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    // FIFO model state
    logic [7:0] fifo_q[$];
    logic [7:0] fifo_level_r;
    logic       uf_model_r;
    logic       force_uf;
    logic       wr_en;
    logic [7:0] wr_data;

    // Scoreboard state
    logic [7:0] exp_q[$];
    int         pop_idx;
    int         pops_total;
    int         lasts_total;
    int         ready_mode;
    logic       hold_vld;
    logic [7:0] hold_data;
    logic       hold_last;
    int         rd_total;
    int         rd_run;
    int         rd_run_max;

    fifo_burst_reader dut (
        .clk             (clk),
        .srst            (srst),
        .fifo_dout       (fifo_dout),
        .fifo_valid      (fifo_valid),
        .fifo_empty      (fifo_empty),
        .fifo_underflow  (fifo_underflow),
        .fifo_data_count (fifo_data_count),
        .fifo_rd_en      (fifo_rd_en),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .busy            (busy),
        .burst_cnt       (burst_cnt),
        .err             (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    assign fifo_data_count = fifo_level_r;
    assign fifo_empty      = (fifo_level_r == 8'd0);
    assign fifo_underflow  = uf_model_r | force_uf;

    // Standard-mode FIFO with 1-cycle read latency, cleared by the shared reset.
    always @(posedge clk) begin
        if (srst) begin
            fifo_q.delete();
            fifo_level_r <= 8'd0;
            fifo_valid   <= 1'b0;
            fifo_dout    <= 8'd0;
            uf_model_r   <= 1'b0;
        end else begin
            fifo_valid <= 1'b0;
            uf_model_r <= 1'b0;
            if (fifo_rd_en) begin
                if (fifo_q.size() > 0) begin
                    fifo_dout  <= fifo_q.pop_front();
                    fifo_valid <= 1'b1;
                end else begin
                    uf_model_r <= 1'b1;
                end
            end
            if (wr_en) fifo_q.push_back(wr_data);
            fifo_level_r <= 8'(fifo_q.size());
        end
        if (fifo_rd_en) begin
            rd_total++;
            rd_run++;
            if (rd_run > rd_run_max) rd_run_max = rd_run;
        end else begin
            rd_run = 0;
        end
    end

    // Downstream sink: drives m_ready, checks order, m_last position and holding.
    always @(negedge clk) begin
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'b0;
            2: m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (srst) begin
            exp_q.delete();
            pop_idx  = 0;
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                checks++;
                if (m_data !== hold_data || m_last !== hold_last) begin
                    errors++;
                    $display("FAIL hold: data=%h last=%b required data=%h last=%b", m_data, m_last, hold_data, hold_last);
                end
            end
            if (m_valid && m_ready) begin
                logic [7:0] exp_b;
                logic       exp_l;
                checks++;
                exp_l = ((pop_idx % BL) == BL - 1);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream: unexpected byte %h, none required", m_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (m_data !== exp_b || m_last !== exp_l) begin
                        errors++;
                        $display("FAIL stream: beat %0d data=%h last=%b required data=%h last=%b", pop_idx, m_data, m_last, exp_b, exp_l);
                    end
                end
                pop_idx++;
                pops_total++;
                if (m_last) lasts_total++;
            end
            hold_vld  = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bytes(input int n, input bit rnd, input int base);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : 8'(base + i);
            wr_en   = 1'b1;
            wr_data = b;
            exp_q.push_back(b);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int exp_bursts);
        int n;
        n = 0;
        while (!(busy == 1'b0 && burst_cnt == 16'(exp_bursts) && exp_q.size() == 0) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (burst_cnt !== 16'(exp_bursts) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL done: burst_cnt=%0d pending=%0d required burst_cnt=%0d pending=0", burst_cnt, exp_q.size(), exp_bursts);
        end
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({fifo_rd_en, m_valid, m_data, m_last, busy, burst_cnt, err} !== 29'd0) begin
            errors++;
            $display("FAIL %s: rd_en=%b m_valid=%b m_data=%h m_last=%b busy=%b burst_cnt=%0d err=%b required all zero",
                     tag, fifo_rd_en, m_valid, m_data, m_last, busy, burst_cnt, err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset");
    endtask

    task automatic test_threshold();
        int first_rd, first_mv, idle_k, rd0, l0;
        bit seen_busy;
        first_rd = -1; first_mv = -1; idle_k = -1; seen_busy = 1'b0;
        ready_mode = 0;
        rd0 = rd_total; l0 = lasts_total; rd_run_max = 0;
        write_bytes(BL, 1'b0, 0);
        for (int k = 0; k < 30; k++) begin
            if (fifo_rd_en && first_rd < 0) first_rd = k;
            if (m_valid && first_mv < 0) first_mv = k;
            if (busy) seen_busy = 1'b1;
            if (seen_busy && !busy && idle_k < 0) idle_k = k;
            tick();
        end
        checks++;
        if (first_rd != 1 || first_mv != 3 || idle_k != BL + 4) begin
            errors++;
            $display("FAIL latency: first_rd=%0d first_valid=%0d idle=%0d required 1 3 %0d", first_rd, first_mv, idle_k, BL + 4);
        end
        checks++;
        if (rd_total - rd0 != BL || rd_run_max != BL) begin
            errors++;
            $display("FAIL reads: count=%0d run=%0d required %0d consecutive", rd_total - rd0, rd_run_max, BL);
        end
        wait_done(1);
        checks++;
        if (lasts_total - l0 != 1 || fifo_level_r !== 8'd0) begin
            errors++;
            $display("FAIL burst1: last pulses=%0d fifo level=%0d required 1 and 0", lasts_total - l0, fifo_level_r);
        end
    endtask

    task automatic test_below_threshold();
        int rd0;
        bit busy_seen;
        rd0 = rd_total; busy_seen = 1'b0;
        write_bytes(BL - 1, 1'b1, 0);
        for (int k = 0; k < 30; k++) begin
            if (busy) busy_seen = 1'b1;
            tick();
        end
        checks++;
        if (rd_total != rd0 || busy_seen) begin
            errors++;
            $display("FAIL below: reads=%0d busy_seen=%b required 0 and 0", rd_total - rd0, busy_seen);
        end
        write_bytes(1, 1'b1, 0);
        wait_done(2);
    endtask

    task automatic test_backpressure();
        int rd0;
        logic [7:0] first_b;
        ready_mode = 1;
        rd0 = rd_total;
        write_bytes(BL, 1'b1, 0);
        first_b = exp_q[0];
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (rd_total - rd0 != 4 || m_valid !== 1'b1 || m_data !== first_b) begin
            errors++;
            $display("FAIL backpressure: reads=%0d m_valid=%b m_data=%h required 4 1 %h", rd_total - rd0, m_valid, m_data, first_b);
        end
        ready_mode = 0;
        wait_done(3);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bp_err: err=%b required 0", err);
        end
    endtask

    task automatic test_alternating();
        int l0;
        l0 = lasts_total;
        ready_mode = 2;
        write_bytes(3 * BL, 1'b1, 0);
        wait_done(6);
        checks++;
        if (lasts_total - l0 != 3) begin
            errors++;
            $display("FAIL alternating: last pulses=%0d required 3", lasts_total - l0);
        end
        ready_mode = 3;
        write_bytes(BL, 1'b1, 0);
        wait_done(7);
        ready_mode = 0;
    endtask

    task automatic test_reset_mid_burst();
        int p0, n, l0;
        p0 = pops_total; n = 0;
        ready_mode = 0;
        write_bytes(BL, 1'b1, 0);
        while (pops_total - p0 < 6 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (pops_total - p0 != 6) begin
            errors++;
            $display("FAIL mid_pops: popped=%0d required 6", pops_total - p0);
        end
        do_reset();
        check_reset_values("reset_mid");
        l0 = lasts_total;
        write_bytes(BL, 1'b1, 0);
        wait_done(1);
        checks++;
        if (lasts_total - l0 != 1) begin
            errors++;
            $display("FAIL after_reset: last pulses=%0d required 1", lasts_total - l0);
        end
    endtask

    task automatic test_error_flag();
        force_uf = 1'b1;
        tick();
        force_uf = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b required 1", err);
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b required 1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
    endtask

    initial begin
        srst = 1'b1; wr_en = 1'b0; wr_data = 8'd0; force_uf = 1'b0; m_ready = 1'b1;
        ready_mode = 0; pop_idx = 0; pops_total = 0; lasts_total = 0; hold_vld = 1'b0;
        rd_total = 0; rd_run = 0; rd_run_max = 0;
        tick();
        test_reset();
        test_threshold();
        test_below_threshold();
        test_backpressure();
        test_alternating();
        test_reset_mid_burst();
        test_error_flag();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
